// File: rtl/ex_stage_md.sv
// Registered MIPS execute stage: operand forwarding, single-cycle ALU, EX/MEM result
// register, and an iterative multiply/divide unit with HI/LO registers.
module ex_stage_md #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned MD_EN   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               ALUSrc1,
  input  logic               ALUSrc2,
  input  logic [3:0]         ALUCtl,
  input  logic               ALU_Sign,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  DataBusA,
  input  logic [DATA_W-1:0]  DataBusB,
  input  logic [DATA_W-1:0]  Imm,
  input  logic [1:0]         MemtoReg,
  input  logic [DATA_W-1:0]  PC_EX,
  input  logic [DATA_W-1:0]  MEMForwardSrc,
  input  logic [DATA_W-1:0]  WBForwardSrc,
  input  logic [1:0]         Forward1,
  input  logic [1:0]         Forward2,
  input  logic               Interrupt,
  input  logic [3:0]         md_op,
  output logic               stall,
  output logic               md_busy,
  output logic               out_valid,
  output logic [DATA_W-1:0]  MEM_ALUOut,
  output logic [DATA_W-1:0]  MEM_WrData,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);
  localparam bit MdOn = (MD_EN != 0);

  localparam logic [3:0] MdMult  = 4'd1;
  localparam logic [3:0] MdMultu = 4'd2;
  localparam logic [3:0] MdDiv   = 4'd3;
  localparam logic [3:0] MdDivu  = 4'd4;
  localparam logic [3:0] MdMfhi  = 4'd5;
  localparam logic [3:0] MdMflo  = 4'd6;
  localparam logic [3:0] MdMthi  = 4'd7;
  localparam logic [3:0] MdMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StRun} md_state_e;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;        // mult: {partial, multiplier}; div: {rem, quo}
  logic [DATA_W-1:0]   mcand_q, mcand_d;    // multiplicand or divisor magnitude
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;        // negate product / quotient
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [DATA_W-1:0]   fwd_a, fwd_b, in1, in2, alu_out, result;
  logic                md_any, md_start_op, md_issue, signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum, div_t, div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] acc_step, prod;
  logic [DATA_W-1:0]   fin_hi, fin_lo;

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_busy = (state_q == StRun);
  assign md_any  = MdOn && (md_op >= MdMult) && (md_op <= MdMtlo);
  assign md_start_op = MdOn && (md_op >= MdMult) && (md_op <= MdDivu);
  assign stall   = in_valid && md_busy && md_any;
  assign md_issue = in_valid && !stall && !Interrupt;

  // Operand forwarding and ALU source selection
  always_comb begin
    case (Forward1)
      2'b00:   fwd_a = DataBusA;
      2'b10:   fwd_a = WBForwardSrc;
      default: fwd_a = MEMForwardSrc;
    endcase
    case (Forward2)
      2'b00:   fwd_b = DataBusB;
      2'b10:   fwd_b = WBForwardSrc;
      default: fwd_b = MEMForwardSrc;
    endcase
    in1 = ALUSrc1 ? {{(DATA_W-SHAMT_W){1'b0}}, shamt} : fwd_a;
    in2 = ALUSrc2 ? Imm : fwd_b;
  end

  // Single-cycle ALU
  always_comb begin
    alu_out = '0;
    case (ALUCtl)
      4'd0:  alu_out = in1 + in2;
      4'd1:  alu_out = in1 - in2;
      4'd2:  alu_out = in1 & in2;
      4'd3:  alu_out = in1 | in2;
      4'd4:  alu_out = in1 ^ in2;
      4'd5:  alu_out = ~(in1 | in2);
      4'd6:  alu_out = in2 << in1[SHAMT_W-1:0];
      4'd7:  alu_out = in2 >> in1[SHAMT_W-1:0];
      4'd8:  alu_out = $signed(in2) >>> in1[SHAMT_W-1:0];
      4'd9:  begin
        if (ALU_Sign) alu_out = {{(DATA_W-1){1'b0}}, ($signed(in1) < $signed(in2))};
        else          alu_out = {{(DATA_W-1){1'b0}}, (in1 < in2)};
      end
      4'd10: alu_out = in2 << (DATA_W / 2);
      default: alu_out = '0;
    endcase
  end

  // Result priority mux
  always_comb begin
    if (Interrupt)                      result = PC_EX;
    else if (MemtoReg == 2'b10)         result = PC_EX + DATA_W'(4);
    else if (MdOn && md_op == MdMfhi)   result = hi_q;
    else if (MdOn && md_op == MdMflo)   result = lo_q;
    else                                result = alu_out;
  end

  // EX/MEM register; a stall inserts a bubble and holds the data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      MEM_ALUOut <= '0;
      MEM_WrData <= '0;
    end else if (stall) begin
      out_valid  <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      MEM_ALUOut <= result;
      MEM_WrData <= fwd_b;
    end
  end

  // MD datapath: operand magnitudes, one iteration step, final sign fix
  always_comb begin
    signed_op = (md_op == MdMult) || (md_op == MdDiv);
    a_neg     = signed_op && fwd_a[DATA_W-1];
    b_neg     = signed_op && fwd_b[DATA_W-1];
    a_mag     = a_neg ? -fwd_a : fwd_a;
    b_mag     = b_neg ? -fwd_b : fwd_b;

    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_t    = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff = div_t - {1'b0, mcand_q};
    div_ge   = (div_t >= {1'b0, mcand_q});
    if (is_div_q) begin
      // Partial remainder stays below the divisor, so both branches fit DATA_W bits
      if (div_ge) acc_step = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      else        acc_step = {div_t[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end

    prod = neg_q ? -acc_step : acc_step;
    if (!is_div_q) begin
      fin_hi = prod[2*DATA_W-1:DATA_W];
      fin_lo = prod[DATA_W-1:0];
    end else if (dz_q) begin
      fin_hi = dividend_q;
      fin_lo = '1;
    end else begin
      fin_hi = neg_rem_q ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];
      fin_lo = neg_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0];
    end
  end

  // MD FSM next state: start/MTHI/MTLO in idle, iterate in run
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md_issue && MdOn) begin
          if (md_op == MdMthi) begin
            hi_d = fwd_a;
          end else if (md_op == MdMtlo) begin
            lo_d = fwd_a;
          end else if (md_start_op) begin
            is_div_d   = (md_op == MdDiv) || (md_op == MdDivu);
            neg_d      = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            dz_d       = (fwd_b == '0);
            dividend_d = fwd_a;
            if (is_div_d) begin
              acc_d   = {{DATA_W{1'b0}}, a_mag};
              mcand_d = b_mag;
            end else begin
              acc_d   = {{DATA_W{1'b0}}, b_mag};
              mcand_d = a_mag;
            end
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // MD state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed cases plus randomized instruction stream
// compared each cycle against a cycle-level behavioural model.
module tb_ex_stage_md;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, ALUSrc1, ALUSrc2, ALU_Sign, Interrupt;
  logic [3:0]    ALUCtl, md_op;
  logic [4:0]    shamt;
  logic [W-1:0]  DataBusA, DataBusB, Imm, PC_EX, MEMForwardSrc, WBForwardSrc;
  logic [1:0]    MemtoReg, Forward1, Forward2;
  logic          stall, md_busy, out_valid;
  logic [W-1:0]  MEM_ALUOut, MEM_WrData, hi, lo;

  ex_stage_md #(.DATA_W(W), .SHAMT_W(5), .MD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .ALUCtl(ALUCtl), .ALU_Sign(ALU_Sign), .shamt(shamt), .DataBusA(DataBusA),
    .DataBusB(DataBusB), .Imm(Imm), .MemtoReg(MemtoReg), .PC_EX(PC_EX),
    .MEMForwardSrc(MEMForwardSrc), .WBForwardSrc(WBForwardSrc), .Forward1(Forward1),
    .Forward2(Forward2), .Interrupt(Interrupt), .md_op(md_op), .stall(stall),
    .md_busy(md_busy), .out_valid(out_valid), .MEM_ALUOut(MEM_ALUOut),
    .MEM_WrData(MEM_WrData), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Model state
  logic [W-1:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_alu, m_wr;
  logic         m_valid;
  int           m_busy_left;
  logic         last_stall;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fwd_sel(input logic [1:0] s, input logic [W-1:0] rf);
    if (s == 2'b00) return rf;
    if (s == 2'b10) return WBForwardSrc;
    return MEMForwardSrc;
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [3:0] ctl, input logic sgn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    int sa = a;
    int sb = b;
    int sh = int'(a[4:0]);
    case (ctl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return b << sh;
      4'd7:  return b >> sh;
      4'd8:  return sb >>> sh;
      4'd9:  return sgn ? W'(sa < sb) : W'(a < b);
      4'd10: return b << 16;
      default: return '0;
    endcase
  endfunction

  // Compute the HI/LO pair a MULT/DIV will deliver
  task automatic md_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa = a;
    int sb = b;
    int unsigned ua = a;
    int unsigned ub = b;
    longint sp;
    longint unsigned up;
    case (op)
      4'd1: begin
        sp = longint'(sa) * longint'(sb);
        m_pend_hi = sp[63:32]; m_pend_lo = sp[31:0];
      end
      4'd2: begin
        up = longint'(ua) * longint'(ub);
        m_pend_hi = up[63:32]; m_pend_lo = up[31:0];
      end
      4'd3: begin
        if (sb == 0) begin m_pend_lo = '1; m_pend_hi = a; end
        else if (sa == 32'sh8000_0000 && sb == -1) begin m_pend_lo = a; m_pend_hi = '0; end
        else begin m_pend_lo = sa / sb; m_pend_hi = sa % sb; end
      end
      default: begin
        if (ub == 0) begin m_pend_lo = '1; m_pend_hi = a; end
        else begin m_pend_lo = ua / ub; m_pend_hi = ua % ub; end
      end
    endcase
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_alu = '0; m_wr = '0; m_valid = 1'b0; m_busy_left = 0;
  endtask

  task automatic nop();
    in_valid = 0; ALUSrc1 = 0; ALUSrc2 = 0; ALUCtl = 0; ALU_Sign = 0; shamt = 0;
    DataBusA = 0; DataBusB = 0; Imm = 0; MemtoReg = 0; PC_EX = 0; MEMForwardSrc = 0;
    WBForwardSrc = 0; Forward1 = 0; Forward2 = 0; Interrupt = 0; md_op = 0;
  endtask

  // One clock: called at posedge+1 with inputs applied; returns at the next posedge+1
  task automatic step();
    logic [W-1:0] fa, fb, i1, i2, res;
    logic md_any, exp_stall;
    fa = fwd_sel(Forward1, DataBusA);
    fb = fwd_sel(Forward2, DataBusB);
    i1 = ALUSrc1 ? {27'b0, shamt} : fa;
    i2 = ALUSrc2 ? Imm : fb;
    if (Interrupt)               res = PC_EX;
    else if (MemtoReg == 2'b10)  res = PC_EX + 32'd4;
    else if (md_op == 4'd5)      res = m_hi;
    else if (md_op == 4'd6)      res = m_lo;
    else                         res = alu_ref(ALUCtl, ALU_Sign, i1, i2);
    md_any    = (md_op >= 4'd1) && (md_op <= 4'd8);
    exp_stall = in_valid && (m_busy_left > 0) && md_any;
    #2;
    check_eq("stall", W'(stall), W'(exp_stall));
    last_stall = stall;
    @(posedge clk);
    #1;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
    end
    if (exp_stall) m_valid = 1'b0;
    else begin m_valid = in_valid; m_alu = res; m_wr = fb; end
    if (in_valid && !exp_stall && !Interrupt) begin
      if (md_op >= 4'd1 && md_op <= 4'd4) begin
        md_ref(md_op, fa, fb);
        m_busy_left = W;
      end else if (md_op == 4'd7) m_hi = fa;
      else if (md_op == 4'd8) m_lo = fa;
    end
    check_eq("out_valid", W'(out_valid), W'(m_valid));
    check_eq("MEM_ALUOut", MEM_ALUOut, m_alu);
    check_eq("MEM_WrData", MEM_WrData, m_wr);
    check_eq("md_busy", W'(md_busy), W'(m_busy_left > 0));
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
  endtask

  // Issue one MULT/DIV, drain it, and check busy length and HI/LO against constants
  task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n = 0;
    nop(); in_valid = 1; md_op = op; DataBusA = a; DataBusB = b;
    step();
    nop();
    while (md_busy && n < 100) begin step(); n++; end
    check_eq({tag, "_cycles"}, W'(n), W'(W));
    check_eq({tag, "_hi"}, hi, ehi);
    check_eq({tag, "_lo"}, lo, elo);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    nop();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", W'(out_valid), '0);
    check_eq("rst_aluout", MEM_ALUOut, '0);
    check_eq("rst_wrdata", MEM_WrData, '0);
    check_eq("rst_busy", W'(md_busy), '0);
    check_eq("rst_hi", hi, '0);
    check_eq("rst_lo", lo, '0);
    reset = 1'b0;

    // ADD with WB forwarding on A
    nop(); in_valid = 1; ALUCtl = 0; Forward1 = 2'b10; WBForwardSrc = 5; DataBusB = 7;
    step();
    check_eq("add_fwd", MEM_ALUOut, 32'd12);
    check_eq("add_valid", W'(out_valid), 32'd1);

    run_md("mult", 4'd1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
    run_md("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", 4'd4, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MULT then dependent MFLO
    nop(); in_valid = 1; md_op = 4'd1; DataBusA = 32'h1234; DataBusB = 32'h10;
    step();
    nop(); in_valid = 1; md_op = 4'd6;
    n = 0;
    do begin step(); if (last_stall) n++; end while (last_stall && n < 100);
    check_eq("mflo_stalls", W'(n), 32'd32);
    check_eq("mflo_val", MEM_ALUOut, 32'h12340);

    // MULT, independent ADD, then MFLO
    nop(); in_valid = 1; md_op = 4'd1; DataBusA = 32'd3; DataBusB = 32'd5;
    step();
    nop(); in_valid = 1; ALUCtl = 0; DataBusA = 32'd20; DataBusB = 32'd22;
    step();
    check_eq("add_nostall", W'(last_stall), '0);
    check_eq("add_mid", MEM_ALUOut, 32'd42);
    nop(); in_valid = 1; md_op = 4'd6;
    n = 0;
    do begin step(); if (last_stall) n++; end while (last_stall && n < 100);
    check_eq("mflo2_stalls", W'(n), 32'd31);
    check_eq("mflo2_val", MEM_ALUOut, 32'd15);

    // Interrupt / link priority, and an MD op under interrupt is not started
    nop(); in_valid = 1; Interrupt = 1; PC_EX = 32'h400; MemtoReg = 2'b10; md_op = 4'd1;
    DataBusA = 32'd3; DataBusB = 32'd3;
    step();
    check_eq("irq_pc", MEM_ALUOut, 32'h400);
    check_eq("irq_nomd", W'(md_busy), '0);
    Interrupt = 0; md_op = 0;
    step();
    check_eq("link_pc4", MEM_ALUOut, 32'h404);

    // Randomized instruction stream
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) != 0);
      ALUSrc1 = $urandom_range(0, 3) == 0; ALUSrc2 = $urandom_range(0, 3) == 0;
      ALUCtl = 4'($urandom_range(0, 15)); ALU_Sign = 1'($urandom);
      shamt = 5'($urandom);
      DataBusA = rnd_val(); DataBusB = rnd_val(); Imm = rnd_val();
      MEMForwardSrc = rnd_val(); WBForwardSrc = rnd_val(); PC_EX = $urandom;
      MemtoReg = 2'($urandom); Forward1 = 2'($urandom); Forward2 = 2'($urandom);
      Interrupt = ($urandom_range(0, 9) == 0);
      md_op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step();
    end
    nop();
    n = 0;
    while (md_busy && n < 100) begin step(); n++; end
    check_eq("drain", W'(md_busy), '0);

    // Reset in the middle of a DIV
    nop(); in_valid = 1; md_op = 4'd3; DataBusA = 32'd1000; DataBusB = 32'd7;
    step();
    nop();
    repeat (9) step();
    #2 reset = 1'b1;
    #1;
    check_eq("mrst_busy", W'(md_busy), '0);
    check_eq("mrst_hi", hi, '0);
    check_eq("mrst_lo", lo, '0);
    check_eq("mrst_valid", W'(out_valid), '0);
    check_eq("mrst_aluout", MEM_ALUOut, '0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    run_md("mult_after_rst", 4'd1, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
Parametrised, registered execute stage for the pipelined MIPS core. It performs operand forwarding and single-cycle ALU operations, and writes its results into an internal EX/MEM result register. It also contains an iterative multiply/divide unit with HI/LO registers. When a HI/LO dependency or structural conflict exists, the stage raises a stall to the hazard unit.

Parameters:
DATA_W, 32, datapath width; must be ≥ 8 and even.
SHAMT_W, 5, shift-amount width; 2^SHAMT_W ≥ DATA_W.
MD_EN, 1, 1 = mult/div unit present; 0 = md ops are treated as NOP and stall is never asserted.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  ID/EX holds a valid instruction
ALUSrc1  in  1  1 = in1 is zero-extended shamt
ALUSrc2  in  1  1 = in2 is Imm
ALUCtl  in  4  ALU op code (see Behaviour)
ALU_Sign  in  1  signed compare for SLT
shamt  in  SHAMT_W  shift amount
DataBusA  in  DATA_W  rs value from register file
DataBusB  in  DATA_W  rt value from register file
Imm  in  DATA_W  extended immediate
MemtoReg  in  2  2'b10 = link (write PC+4)
PC_EX  in  DATA_W  PC of the instruction in EX
MEMForwardSrc  in  DATA_W  forwarded value from the MEM stage
WBForwardSrc  in  DATA_W  forwarded value from the WB stage
Forward1  in  2  source select for operand A
Forward2  in  2  source select for operand B
Interrupt  in  1  interrupt taken on this instruction
md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; all other codes are NONE
stall  out  1  combinational; hold IF/ID/EX this cycle
md_busy  out  1  iterative operation in flight
out_valid  out  1  registered; EX/MEM entry valid
MEM_ALUOut  out  DATA_W  registered result
MEM_WrData  out  DATA_W  registered store data (forwarded rt)
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register

Behaviour:
- Forward select (applies to both Forward1 and Forward2): 00 = register bus, 10 = WB, 01/11 = MEM.
- in1 = ALUSrc1 ? zext(shamt) : fwdA.
- in2 = ALUSrc2 ? Imm : fwdB.
- ALUCtl codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA: shift in2 by in1[SHAMT_W-1:0].
  - 9 SLT: signed if ALU_Sign, else unsigned; result 0/1.
  - 10 LUI: in2 << DATA_W/2.
  - Other codes → 0.
  - Add/sub wrap modulo 2^DATA_W; no overflow flag.
- Result mux, in priority order: Interrupt → PC_EX; MemtoReg==10 → PC_EX+4; MFHI → hi; MFLO → lo; else ALU output.
- stall = in_valid & md_busy & md_op ∈ {1..8}. ALU-only instructions never stall while md_busy.
- EX/MEM register update on posedge clk:
  - If stall: out_valid ← 0 (bubble); MEM_ALUOut and MEM_WrData hold.
  - Else: out_valid ← in_valid; MEM_ALUOut ← result; MEM_WrData ← fwdB.
- MD unit FSM:
  - IDLE: an edge with in_valid & !stall & !Interrupt & md_op ∈ {1..4} latches fwdA/fwdB and the op, then moves to RUN with count ← 0.
  - MTHI/MTLO under the same conditions write fwdA to hi/lo at that edge.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle on magnitudes. Signed ops take absolute values and sign-fix the final result.
  - After DATA_W steps, hi/lo are written on the same edge and the FSM returns to IDLE.
  - md_busy = (state == RUN).
  - Product: {hi,lo} = 2·DATA_W-bit product.
  - Divide: lo = quotient, hi = remainder; the remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = dividend; still takes DATA_W cycles.
  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0.
- Interrupt does not abort an in-flight MD op. An MD op arriving with Interrupt high is not started.
- Reset, asynchronous at any time including mid-operation: state = IDLE, count = 0, hi = lo = 0, out_valid = 0, MEM_ALUOut = 0, MEM_WrData = 0.
- Latency:
  - ALU result is visible 1 cycle after issue.
  - A MULT/DIV issued at edge E gives md_busy high for cycles E..E+DATA_W−1 and hi/lo valid after edge E+DATA_W.
  - A dependent MFHI issued immediately after stalls exactly DATA_W cycles.

Test Plan:
- ADD with Forward1=10, WB=5, DataBusB=7, Forward2=00 → next cycle MEM_ALUOut=12, out_valid=1.
- MULT -3×4 (DATA_W=32) → md_busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4; MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 9/0 → lo=0xFFFFFFFF, hi=9.
- MULT followed by MFLO → stall high 32 cycles with out_valid=0 bubbles, then MEM_ALUOut=product low; an interleaved ADD between them completes with no stall.
- Interrupt=1 with PC_EX=0x400 and MemtoReg=10 → MEM_ALUOut=0x400; with Interrupt=0 → 0x404.
- Assert reset at cycle 10 of a DIV → md_busy=0, hi=lo=0, out_valid=0 immediately; a new MULT after reset completes correctly.
